axi_wr_slave_p: RTL

Parametrised AXI4 write slave that turns AW/W bursts into single-beat internal writes toward NREG sink regions (fifo, iram, wram, …) and returns one B response per burst. It supports FIXED, INCR and, optionally, WRAP bursts, and checks burst legality. It waits for a per-region write-done on every beat, with a watchdog on that wait, and sits between the AXI interconnect and the RAM/FIFO sinks.

---
 rtl/axi_wr_slave_p_if.sv | 46 ++++
 rtl/axi_wr_slave_p.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/axi_wr_slave_p_if.sv
// AXI4 write-channel bundle (AW, W, B) used by axi_wr_slave_p.
interface axi_wr_slave_p_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned ID_W   = 8
);
  localparam int unsigned SW = DATA_W / 8;

  logic [ID_W-1:0]   AWID;
  logic [ADDR_W-1:0] AWADDR;
  logic [7:0]        AWLEN;
  logic [2:0]        AWSIZE;
  logic [1:0]        AWBURST;
  logic [3:0]        AWREGION;
  logic              AWVALID;
  logic              AWREADY;

  logic [DATA_W-1:0] WDATA;
  logic [SW-1:0]     WSTRB;
  logic              WLAST;
  logic              WVALID;
  logic              WREADY;

  logic [ID_W-1:0]   BID;
  logic [1:0]        BRESP;
  logic              BVALID;
  logic              BREADY;

  modport master (
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWREGION, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );

  modport slave (
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWREGION, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );
endinterface

// File: rtl/axi_wr_slave_p.sv
// AXI4 write slave: splits AW/W bursts into single-beat sink writes, one B per burst.
// WRAP bursts are supported only when AXI_WR_WRAP_EN is defined.
module axi_wr_slave_p #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 11,
  parameter int unsigned ID_W   = 8,
  parameter int unsigned NREG   = 3,
  parameter int unsigned TMO    = 255,
  localparam int unsigned SW    = DATA_W / 8,
  localparam int unsigned RW    = (NREG > 1) ? $clog2(NREG) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  axi_wr_slave_p_if.slave   bus,
  output logic              axi_wr_vld,
  output logic [ADDR_W-1:0] axi_wr_addr,
  output logic [DATA_W-1:0] axi_wr_data,
  output logic [SW-1:0]     axi_wr_strb,
  output logic [RW-1:0]     axi_wr_region,
  input  logic [NREG-1:0]   wr_done,
  input  logic [NREG-1:0]   wr_err
);

  localparam int unsigned MaxSize = $clog2(SW);
  localparam int unsigned TW      = (TMO > 1) ? $clog2(TMO + 1) : 1;
  localparam int unsigned TmoLast = (TMO > 0) ? TMO - 1 : 0;

  localparam logic [1:0] RespOkay   = 2'd0;
  localparam logic [1:0] RespSlvErr = 2'd2;
  localparam logic [1:0] RespDecErr = 2'd3;
  localparam logic [1:0] BurstIncr  = 2'd1;
  localparam logic [1:0] BurstWrap  = 2'd2;

  typedef enum logic [1:0] {StIdle, StData, StWait, StResp} state_e;

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [RW-1:0]     region_q;
  logic [1:0]        err_q;
  logic [7:0]        beat_q;
  logic              last_q;
  logic [TW-1:0]     wd_q;
  logic              vld_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [DATA_W-1:0] wr_data_q;
  logic [SW-1:0]     wr_strb_q;

  logic              aw_hs, w_hs, beat_last;
  logic              done_sel, err_sel, timeout, wait_exit;
  logic [1:0]        aw_err;
  logic [ADDR_W-1:0] beat_bytes, addr_nxt;
`ifdef AXI_WR_WRAP_EN
  logic [ADDR_W-1:0] aw_mask, wrap_mask;
`endif

  assign aw_hs     = (state_q == StIdle) && bus.AWVALID;
  assign w_hs      = (state_q == StData) && bus.WVALID;
  assign beat_last = (beat_q == len_q);

  // Legality of the incoming burst; decode errors outrank protocol errors.
  always_comb begin
    aw_err = RespOkay;
`ifdef AXI_WR_WRAP_EN
    aw_mask = (ADDR_W'(1) << bus.AWSIZE) - ADDR_W'(1);
`endif
    if (32'(bus.AWREGION) >= NREG) begin
      aw_err = RespDecErr;
    end else if ((32'(bus.AWSIZE) > MaxSize) || (bus.AWBURST == 2'd3)) begin
      aw_err = RespSlvErr;
    end else if (bus.AWBURST == BurstWrap) begin
`ifdef AXI_WR_WRAP_EN
      if (!(bus.AWLEN inside {8'd1, 8'd3, 8'd7, 8'd15}) || ((bus.AWADDR & aw_mask) != '0)) begin
        aw_err = RespSlvErr;
      end
`else
      aw_err = RespSlvErr;
`endif
    end
  end

  always_comb begin
    beat_bytes = ADDR_W'(1) << size_q;
`ifdef AXI_WR_WRAP_EN
    wrap_mask  = (beat_bytes * ADDR_W'({1'b0, len_q} + 9'd1)) - ADDR_W'(1);
`endif
    case (burst_q)
      BurstIncr: addr_nxt = (addr_q & ~(beat_bytes - ADDR_W'(1))) + beat_bytes;
`ifdef AXI_WR_WRAP_EN
      BurstWrap: addr_nxt = (addr_q & ~wrap_mask) | ((addr_q + beat_bytes) & wrap_mask);
`endif
      default:   addr_nxt = addr_q;
    endcase
  end

  always_comb begin
    done_sel = 1'b0;
    err_sel  = 1'b0;
    for (int unsigned i = 0; i < NREG; i++) begin
      if (32'(region_q) == i) begin
        done_sel = wr_done[i];
        err_sel  = wr_err[i];
      end
    end
  end

  assign timeout   = (TMO != 0) && (wd_q == TW'(TmoLast));
  assign wait_exit = (state_q == StWait) && (done_sel || timeout);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (bus.AWVALID) state_d = StData;
      StData: begin
        if (bus.WVALID) begin
          if (err_q == RespOkay) state_d = StWait;
          else if (bus.WLAST)    state_d = StResp;
        end
      end
      StWait: if (wait_exit) state_d = last_q ? StResp : StData;
      StResp: if (bus.BREADY) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      region_q  <= '0;
      err_q     <= RespOkay;
      beat_q    <= '0;
      last_q    <= 1'b0;
      wd_q      <= '0;
      vld_q     <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_strb_q <= '0;
    end else begin
      state_q <= state_d;
      vld_q   <= 1'b0;
      wd_q    <= (state_q == StWait) ? wd_q + TW'(1) : '0;
      if (aw_hs) begin
        id_q     <= bus.AWID;
        addr_q   <= bus.AWADDR;
        len_q    <= bus.AWLEN;
        size_q   <= bus.AWSIZE;
        burst_q  <= bus.AWBURST;
        region_q <= RW'(bus.AWREGION);
        err_q    <= aw_err;
        beat_q   <= '0;
      end
      if (w_hs) begin
        last_q <= bus.WLAST;
        if (beat_q != 8'hff) beat_q <= beat_q + 8'd1;
        // A beat is written on the error-free state seen at its handshake, even if it trips WLAST.
        if (err_q == RespOkay) begin
          vld_q     <= 1'b1;
          wr_addr_q <= addr_q;
          wr_data_q <= bus.WDATA;
          wr_strb_q <= bus.WSTRB;
          addr_q    <= addr_nxt;
          if (bus.WLAST != beat_last) err_q <= RespSlvErr;
        end
      end
      if (wait_exit && (err_q == RespOkay) && (done_sel ? err_sel : 1'b1)) begin
        err_q <= RespSlvErr;
      end
    end
  end

  // Outputs are forced low while reset is held so they read zero within the reset cycle.
  assign bus.AWREADY   = rst_n && (state_q == StIdle);
  assign bus.WREADY    = rst_n && (state_q == StData);
  assign bus.BVALID    = rst_n && (state_q == StResp);
  assign bus.BID       = bus.BVALID ? id_q : '0;
  assign bus.BRESP     = bus.BVALID ? err_q : RespOkay;
  assign axi_wr_vld    = rst_n && vld_q;
  assign axi_wr_addr   = rst_n ? wr_addr_q : '0;
  assign axi_wr_data   = rst_n ? wr_data_q : '0;
  assign axi_wr_strb   = rst_n ? wr_strb_q : '0;
  assign axi_wr_region = rst_n ? region_q : '0;

endmodule
